// File: rtl/sync_polarity_controller.sv
// sync_polarity_controller
// Sequences the BKM-68X sync polarity detector. It holds the detector in reset
// while sync is absent and confirms the detector's verdict over spaced samples.
// It then drives a normalized sync, a latched polarity and a lock flag.
// Detection is re-run on sync loss, on a confirmed polarity change or on request.
module sync_polarity_controller #(
  parameter int ACT_TIMEOUT      = 262144,
  parameter int DET_RESET_CYCLES = 16,
  parameter int SETTLE_CYCLES    = 2097152,
  parameter int SAMPLE_INTERVAL  = 65536,
  parameter int CONFIRM_SAMPLES  = 4
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_n,
  input  logic       sync_in,
  input  logic       det_polarity_in,
  input  logic       force_relock_in,
  output logic       det_reset_out,
  output logic       polarity_out,
  output logic       sync_norm_out,
  output logic       locked_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ST_NO_SYNC   = 3'd0,
    ST_RESET_DET = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CONFIRM   = 3'd3,
    ST_LOCKED    = 3'd4
  } state_t;

  localparam int IW = $clog2(ACT_TIMEOUT + 1);
  localparam int DW = $clog2(DET_RESET_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(SAMPLE_INTERVAL + 1);
  localparam int CW = $clog2(CONFIRM_SAMPLES + 1);

  localparam logic [IW-1:0] IDLE_MAX    = IW'(ACT_TIMEOUT);
  localparam logic [DW-1:0] RST_LAST    = DW'(DET_RESET_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] SAMP_LAST   = PW'(SAMPLE_INTERVAL - 1);
  localparam logic [CW-1:0] CONF_TARGET = CW'(CONFIRM_SAMPLES);
  localparam logic [CW-1:0] RUN_LAST    = CW'(CONFIRM_SAMPLES - 1);

  // Synchronizer and activity watchdog registers
  logic          r_sync_meta;
  logic          r_sync_s;
  logic          r_sync_d;
  logic [IW-1:0] r_idle_cnt;

  // FSM state and sequencing counters
  state_t        r_state;
  logic [DW-1:0] r_rst_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [PW-1:0] r_samp_cnt;
  logic [CW-1:0] r_match_cnt;
  logic          r_ref;
  logic [CW-1:0] r_run_cnt;

  // Registered outputs
  logic          r_polarity;
  logic          r_det_reset;
  logic          r_locked;
  logic          r_sync_norm;

  // Combinational next-state values
  logic          w_edge;
  logic          w_lost;
  logic          w_lost_take;
  logic          w_force_take;
  logic          w_samp_now;
  logic [PW-1:0] w_samp_adv;
  state_t        w_state_nxt;
  logic [DW-1:0] w_rst_cnt_nxt;
  logic [SW-1:0] w_settle_cnt_nxt;
  logic [PW-1:0] w_samp_cnt_nxt;
  logic [CW-1:0] w_match_cnt_nxt;
  logic          w_ref_nxt;
  logic [CW-1:0] w_run_cnt_nxt;
  logic          w_pol_nxt;

  // An edge in the same cycle as a saturated watchdog suppresses the loss.
  assign w_edge = r_sync_s ^ r_sync_d;
  assign w_lost = (r_idle_cnt == IDLE_MAX) && !w_edge;

  // Bring raw sync into the clock domain and time the gap since the last edge
  always_ff @(posedge clk_50mhz_in) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b0;
      r_sync_s    <= 1'b0;
      r_sync_d    <= 1'b0;
      r_idle_cnt  <= {IW{1'b0}};
    end else begin
      r_sync_meta <= sync_in;
      r_sync_s    <= r_sync_meta;
      r_sync_d    <= r_sync_s;
      if (w_edge) begin
        r_idle_cnt <= {IW{1'b0}};
      end else if (r_idle_cnt != IDLE_MAX) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt;
      end
    end
  end

  // Next state and counter updates. Sync loss wins over a relock request,
  // and both win over the per-state transitions.
  always_comb begin
    w_state_nxt      = r_state;
    w_rst_cnt_nxt    = r_rst_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_samp_cnt_nxt   = r_samp_cnt;
    w_match_cnt_nxt  = r_match_cnt;
    w_ref_nxt        = r_ref;
    w_run_cnt_nxt    = r_run_cnt;
    w_pol_nxt        = r_polarity;
    w_lost_take      = w_lost && (r_state != ST_NO_SYNC);
    w_force_take     = force_relock_in && (r_state != ST_NO_SYNC);
    w_samp_now       = (r_samp_cnt == {PW{1'b0}});
    w_samp_adv       = (r_samp_cnt == SAMP_LAST) ? {PW{1'b0}} : (r_samp_cnt + 1'b1);

    if (w_lost_take) begin
      w_state_nxt = ST_NO_SYNC;
    end else if (w_force_take) begin
      // Covers RESET_DET too: re-entry restarts the reset count.
      w_state_nxt   = ST_RESET_DET;
      w_rst_cnt_nxt = {DW{1'b0}};
    end else begin
      case (r_state)
        ST_NO_SYNC: begin
          if (w_edge) begin
            w_state_nxt   = ST_RESET_DET;
            w_rst_cnt_nxt = {DW{1'b0}};
          end else begin
            w_state_nxt = ST_NO_SYNC;
          end
        end
        ST_RESET_DET: begin
          if (r_rst_cnt == RST_LAST) begin
            w_state_nxt      = ST_SETTLE;
            w_settle_cnt_nxt = {SW{1'b0}};
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            w_state_nxt     = ST_CONFIRM;
            w_samp_cnt_nxt  = {PW{1'b0}};
            w_match_cnt_nxt = {CW{1'b0}};
          end else begin
            w_settle_cnt_nxt = r_settle_cnt + 1'b1;
          end
        end
        ST_CONFIRM: begin
          w_samp_cnt_nxt = w_samp_adv;
          if (w_samp_now) begin
            // A zero match count means no reference has been taken yet.
            if ((r_match_cnt == {CW{1'b0}}) || (det_polarity_in != r_ref)) begin
              w_ref_nxt       = det_polarity_in;
              w_match_cnt_nxt = {{(CW-1){1'b0}}, 1'b1};
            end else begin
              w_match_cnt_nxt = r_match_cnt + 1'b1;
            end
            if (w_match_cnt_nxt == CONF_TARGET) begin
              w_state_nxt   = ST_LOCKED;
              w_pol_nxt     = w_ref_nxt;
              w_run_cnt_nxt = {CW{1'b0}};
            end else begin
              w_state_nxt = ST_CONFIRM;
            end
          end else begin
            w_state_nxt = ST_CONFIRM;
          end
        end
        ST_LOCKED: begin
          w_samp_cnt_nxt = w_samp_adv;
          if (w_samp_now) begin
            if (det_polarity_in != r_polarity) begin
              if (r_run_cnt == RUN_LAST) begin
                w_state_nxt   = ST_RESET_DET;
                w_rst_cnt_nxt = {DW{1'b0}};
              end else begin
                w_run_cnt_nxt = r_run_cnt + 1'b1;
              end
            end else begin
              w_run_cnt_nxt = {CW{1'b0}};
            end
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
        default: begin
          w_state_nxt = ST_NO_SYNC;
        end
      endcase
    end
  end

  // Commit FSM state and sequencing counters
  always_ff @(posedge clk_50mhz_in) begin
    if (!reset_n) begin
      r_state      <= ST_NO_SYNC;
      r_rst_cnt    <= {DW{1'b0}};
      r_settle_cnt <= {SW{1'b0}};
      r_samp_cnt   <= {PW{1'b0}};
      r_match_cnt  <= {CW{1'b0}};
      r_ref        <= 1'b0;
      r_run_cnt    <= {CW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_samp_cnt   <= w_samp_cnt_nxt;
      r_match_cnt  <= w_match_cnt_nxt;
      r_ref        <= w_ref_nxt;
      r_run_cnt    <= w_run_cnt_nxt;
    end
  end

  // Register outputs from the next state so they move with the transition
  always_ff @(posedge clk_50mhz_in) begin
    if (!reset_n) begin
      r_det_reset <= 1'b1;
      r_locked    <= 1'b0;
      r_polarity  <= 1'b0;
      r_sync_norm <= 1'b0;
    end else begin
      r_det_reset <= (w_state_nxt == ST_NO_SYNC) || (w_state_nxt == ST_RESET_DET);
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_polarity  <= w_pol_nxt;
      r_sync_norm <= r_locked & ~(r_sync_s ^ r_polarity);
    end
  end

  assign det_reset_out = r_det_reset;
  assign polarity_out  = r_polarity;
  assign sync_norm_out = r_sync_norm;
  assign locked_out    = r_locked;
  assign state_out     = r_state;

endmodule

// File: tb/tb_sync_polarity_controller.sv
// Directed testbench for sync_polarity_controller with reduced parameters.
// Reference times are counted in ticks relative to RESET_DET entry (rel = 0).
module tb_sync_polarity_controller;

  logic       clk;
  logic       reset_n;
  logic       sync_in;
  logic       det_polarity_in;
  logic       force_relock_in;
  logic       det_reset_out;
  logic       polarity_out;
  logic       sync_norm_out;
  logic       locked_out;
  logic [2:0] state_out;

  int         n_vec;
  int         n_err;
  int         rel;
  int         phase;
  bit         sync_run;
  logic [7:0] hist;

  sync_polarity_controller #(
    .ACT_TIMEOUT     (64),
    .DET_RESET_CYCLES(4),
    .SETTLE_CYCLES   (32),
    .SAMPLE_INTERVAL (8),
    .CONFIRM_SAMPLES (3)
  ) dut (
    .clk_50mhz_in   (clk),
    .reset_n        (reset_n),
    .sync_in        (sync_in),
    .det_polarity_in(det_polarity_in),
    .force_relock_in(force_relock_in),
    .det_reset_out  (det_reset_out),
    .polarity_out   (polarity_out),
    .sync_norm_out  (sync_norm_out),
    .locked_out     (locked_out),
    .state_out      (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: wait for the falling edge, then drive the sync pattern (10 high, 2 low).
  task tick();
    @(negedge clk);
    if (sync_run) begin
      sync_in = (phase < 10) ? 1'b1 : 1'b0;
      phase   = (phase == 11) ? 0 : phase + 1;
    end
    hist = {hist[6:0], sync_in};
    rel  = rel + 1;
  endtask

  task tick_to(input int n);
    while (rel < n) tick();
  endtask

  task do_reset();
    reset_n         = 1'b0;
    sync_run        = 1'b0;
    phase           = 0;
    sync_in         = 1'b0;
    det_polarity_in = 1'b0;
    force_relock_in = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // First sync rise is driven here; RESET_DET is entered three edges later (rel 0).
  task start_sync();
    phase    = 0;
    sync_run = 1'b1;
    tick();
    rel = -3;
  endtask

  task test_reset();
    reset_n         = 1'b0;
    sync_in         = 1'b0;
    det_polarity_in = 1'b1;
    force_relock_in = 1'b0;
    tick();
    tick();
    n_vec++; if (state_out !== 3'd0)    begin n_err++; $display("FAIL rst_state: got %0d expected 0", state_out); end
    n_vec++; if (det_reset_out !== 1'b1) begin n_err++; $display("FAIL rst_det_reset: got %b expected 1", det_reset_out); end
    n_vec++; if (polarity_out !== 1'b0)  begin n_err++; $display("FAIL rst_polarity: got %b expected 0", polarity_out); end
    n_vec++; if (locked_out !== 1'b0)    begin n_err++; $display("FAIL rst_locked: got %b expected 0", locked_out); end
    n_vec++; if (sync_norm_out !== 1'b0) begin n_err++; $display("FAIL rst_sync_norm: got %b expected 0", sync_norm_out); end
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      n_vec++;
      if ((state_out !== 3'd0) || (det_reset_out !== 1'b1) || (locked_out !== 1'b0) || (sync_norm_out !== 1'b0)) begin
        n_err++;
        $display("FAIL idle_no_sync cycle %0d: got state=%0d det_rst=%b lock=%b norm=%b expected 0 1 0 0",
                 i, state_out, det_reset_out, locked_out, sync_norm_out);
      end
    end
  endtask

  task test_lock_basic();
    do_reset();
    start_sync();
    tick_to(-1);
    n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL pre_entry_state: got %0d expected 0", state_out); end
    for (int t = 0; t < 4; t++) begin
      tick_to(t);
      n_vec++;
      if ((state_out !== 3'd1) || (det_reset_out !== 1'b1)) begin
        n_err++;
        $display("FAIL reset_det_hold rel %0d: got state=%0d det_rst=%b expected 1 1", t, state_out, det_reset_out);
      end
    end
    tick_to(4);
    n_vec++; if ((state_out !== 3'd2) || (det_reset_out !== 1'b0)) begin n_err++; $display("FAIL settle_entry: got state=%0d det_rst=%b expected 2 0", state_out, det_reset_out); end
    tick_to(36);
    n_vec++; if (state_out !== 3'd3) begin n_err++; $display("FAIL confirm_entry: got %0d expected 3", state_out); end
    tick_to(52);
    n_vec++; if (locked_out !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b expected 0", locked_out); end
    tick_to(53);
    n_vec++; if ((locked_out !== 1'b1) || (state_out !== 3'd4) || (polarity_out !== 1'b0)) begin
      n_err++; $display("FAIL lock_at_53: got lock=%b state=%0d pol=%b expected 1 4 0", locked_out, state_out, polarity_out);
    end
    for (int t = 55; t <= 80; t++) begin
      tick_to(t);
      n_vec++;
      if (sync_norm_out !== ~hist[3]) begin
        n_err++; $display("FAIL sync_norm_inv rel %0d: got %b expected %b", t, sync_norm_out, ~hist[3]);
      end
    end
  endtask

  task test_toggle_confirm();
    do_reset();
    det_polarity_in = 1'b1;
    start_sync();
    tick_to(40);
    det_polarity_in = 1'b0;
    tick_to(53);
    n_vec++; if ((locked_out !== 1'b0) || (state_out !== 3'd3)) begin n_err++; $display("FAIL toggle_no_lock_53: got lock=%b state=%0d expected 0 3", locked_out, state_out); end
    tick_to(60);
    n_vec++; if (locked_out !== 1'b0) begin n_err++; $display("FAIL toggle_no_lock_60: got %b expected 0", locked_out); end
    tick_to(61);
    n_vec++; if ((locked_out !== 1'b1) || (polarity_out !== 1'b0)) begin n_err++; $display("FAIL toggle_lock_61: got lock=%b pol=%b expected 1 0", locked_out, polarity_out); end
  endtask

  task test_polarity_change();
    do_reset();
    start_sync();
    tick_to(60);
    det_polarity_in = 1'b1;
    tick_to(76);
    n_vec++; if ((state_out !== 3'd4) || (locked_out !== 1'b1)) begin n_err++; $display("FAIL polchg_still_locked: got state=%0d lock=%b expected 4 1", state_out, locked_out); end
    tick_to(77);
    n_vec++; if ((state_out !== 3'd1) || (locked_out !== 1'b0) || (det_reset_out !== 1'b1) || (polarity_out !== 1'b0)) begin
      n_err++; $display("FAIL polchg_relock: got state=%0d lock=%b det_rst=%b pol=%b expected 1 0 1 0", state_out, locked_out, det_reset_out, polarity_out);
    end
    tick_to(78);
    n_vec++; if (sync_norm_out !== 1'b0) begin n_err++; $display("FAIL polchg_norm_off: got %b expected 0", sync_norm_out); end
    tick_to(77 + 52);
    n_vec++; if ((locked_out !== 1'b0) || (polarity_out !== 1'b0)) begin n_err++; $display("FAIL polchg_pre_lock: got lock=%b pol=%b expected 0 0", locked_out, polarity_out); end
    tick_to(77 + 53);
    n_vec++; if ((locked_out !== 1'b1) || (polarity_out !== 1'b1)) begin n_err++; $display("FAIL polchg_new_lock: got lock=%b pol=%b expected 1 1", locked_out, polarity_out); end
  endtask

  task test_sync_loss();
    do_reset();
    det_polarity_in = 1'b1;
    start_sync();
    tick_to(60);
    n_vec++; if ((state_out !== 3'd4) || (polarity_out !== 1'b1)) begin n_err++; $display("FAIL loss_locked: got state=%0d pol=%b expected 4 1", state_out, polarity_out); end
    sync_run = 1'b0;
    tick();
    sync_in = ~sync_in;
    repeat (67) tick();
    n_vec++; if ((state_out !== 3'd4) || (locked_out !== 1'b1)) begin n_err++; $display("FAIL loss_not_yet: got state=%0d lock=%b expected 4 1", state_out, locked_out); end
    tick();
    n_vec++; if ((state_out !== 3'd0) || (locked_out !== 1'b0) || (det_reset_out !== 1'b1) || (polarity_out !== 1'b1)) begin
      n_err++; $display("FAIL loss_no_sync: got state=%0d lock=%b det_rst=%b pol=%b expected 0 0 1 1", state_out, locked_out, det_reset_out, polarity_out);
    end
    tick();
    n_vec++; if (sync_norm_out !== 1'b0) begin n_err++; $display("FAIL loss_norm_off: got %b expected 0", sync_norm_out); end
  endtask

  task test_force_relock();
    do_reset();
    start_sync();
    tick_to(60);
    n_vec++; if (state_out !== 3'd4) begin n_err++; $display("FAIL force_pre_locked: got %0d expected 4", state_out); end
    force_relock_in = 1'b1;
    tick_to(61);
    force_relock_in = 1'b0;
    n_vec++; if ((state_out !== 3'd1) || (locked_out !== 1'b0) || (det_reset_out !== 1'b1)) begin
      n_err++; $display("FAIL force_from_locked: got state=%0d lock=%b det_rst=%b expected 1 0 1", state_out, locked_out, det_reset_out);
    end
    tick_to(63);
    force_relock_in = 1'b1;
    tick_to(64);
    force_relock_in = 1'b0;
    tick_to(67);
    n_vec++; if ((state_out !== 3'd1) || (det_reset_out !== 1'b1)) begin n_err++; $display("FAIL force_restart_hold: got state=%0d det_rst=%b expected 1 1", state_out, det_reset_out); end
    tick_to(68);
    n_vec++; if ((state_out !== 3'd2) || (det_reset_out !== 1'b0)) begin n_err++; $display("FAIL force_restart_settle: got state=%0d det_rst=%b expected 2 0", state_out, det_reset_out); end
    do_reset();
    tick();
    force_relock_in = 1'b1;
    tick();
    force_relock_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ((state_out !== 3'd0) || (det_reset_out !== 1'b1)) begin
        n_err++; $display("FAIL force_in_no_sync %0d: got state=%0d det_rst=%b expected 0 1", i, state_out, det_reset_out);
      end
    end
  endtask

  task test_reset_mid_confirm();
    do_reset();
    det_polarity_in = 1'b1;
    start_sync();
    tick_to(60);
    force_relock_in = 1'b1;
    tick_to(61);
    force_relock_in = 1'b0;
    tick_to(100);
    n_vec++; if ((state_out !== 3'd3) || (polarity_out !== 1'b1)) begin n_err++; $display("FAIL mid_in_confirm: got state=%0d pol=%b expected 3 1", state_out, polarity_out); end
    reset_n = 1'b0;
    tick_to(101);
    reset_n = 1'b1;
    n_vec++; if ((state_out !== 3'd0) || (det_reset_out !== 1'b1) || (polarity_out !== 1'b0) || (locked_out !== 1'b0) || (sync_norm_out !== 1'b0)) begin
      n_err++; $display("FAIL mid_reset_values: got state=%0d det_rst=%b pol=%b lock=%b norm=%b expected 0 1 0 0 0",
               state_out, det_reset_out, polarity_out, locked_out, sync_norm_out);
    end
    tick_to(102);
    n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL mid_reset_hold: got %0d expected 0", state_out); end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rel             = 0;
    phase           = 0;
    sync_run        = 1'b0;
    hist            = 8'h00;
    reset_n         = 1'b0;
    sync_in         = 1'b0;
    det_polarity_in = 1'b0;
    force_relock_in = 1'b0;
    test_reset();
    test_lock_basic();
    test_toggle_confirm();
    test_polarity_change();
    test_sync_loss();
    test_force_relock();
    test_reset_mid_confirm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
